id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between instruction decode and execute in the 5-stage MIPS core. It latches the decoded control word, the operand data and the register fields produced in ID. It also detects load-use hazards against the instruction currently in EX. On a hazard it raises a stall request for the PC and IF/ID register and injects a bubble into EX. It honours a branch flush and keeps a saturating count of bubbles inserted.

## Interface
- `DATA_W`, 32: operand, immediate and PC width.
- `CNT_W`, 16: bubble counter width.

Ports:
- `Clk`  in  1: single clock; all state updates on rising edge.
- `Rst`  in  1: synchronous, active-high reset.
- `RegDstIn, BranchIn, MemReadIn, MemtoRegIn, MemWriteIn, ALUSrcIn, RegWriteIn`  in  1 each: control bits from control unit, aligned with ID data.
- `ALUOpIn`  in  4: ALU operation code (2 ADD, 6 SUB, 0 AND, 1 OR, 7 SLT, 12 NOR, 3 SLL).
- `ReadData1In, ReadData2In, ImmIn, PCPlus4In`  in  DATA_W: register file outputs, sign-extended immediate, PC+4.
- `RsIn, RtIn, RdIn`  in  5: instruction register fields.
- `Flush`  in  1: branch/jump taken; kill instruction entering EX.
- `RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite`  out  1: registered EX control.
- `ALUOp`  out  4: registered ALU op.
- `ReadData1, ReadData2, Imm, PCPlus4`  out  DATA_W: registered data.
- `Rs, Rt, Rd`  out  5: registered fields.
- `Valid`  out  1: EX slot holds a real instruction.
- `Stall`  out  1: combinational; hold PC and IF/ID this cycle.
- `BubbleCount`  out  CNT_W: saturating count of bubbles inserted.

## Operation
- **Hazard condition (comb.):** `Haz = Valid & MemRead & (Rt != 0) & ((Rt == RsIn) | (Rt == RtIn))`.
- `Stall = Haz & ~Flush`.
- **Priority at each edge:** Rst > Flush > Haz > load.
- **Rst:** all outputs 0, including `Valid`, `ALUOp` and `BubbleCount`.
- **Flush:** load a bubble with `Valid`=0. `BubbleCount` does not increment. A flush while `Haz` is true drops the stall; the dependent instruction is killed anyway.
- **Haz (no Flush):** load a bubble and increment `BubbleCount`, saturating at 2^CNT_W−1.
- **Normal:** load all inputs; `Valid`=1.
- **Bubble definition:**
  - Cleared: `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `Valid`.
  - Zero: `RegDst`, `MemtoReg`, `ALUSrc`, `ALUOp`, `Rs`, `Rt`, `Rd`.
  - Data fields: hold their previous value (don't-care).
- **Internal state:** implicit two states, RUN and BUBBLE (`Valid`=0 after Flush/Haz/Rst). The next edge after a bubble always loads normally, because the bubble has `MemRead`=0. A single load-use therefore costs exactly one stall cycle.
- **Don't-care control bits** (x on `RegDstIn`/`MemtoRegIn` for SW/BEQ): pass through unchanged. The bubble forces 0.

## Timing
- Latency: one cycle from ID inputs to EX outputs.
- `Stall` is valid in the same cycle as the ID inputs, from registered EX state plus current `RsIn`/`RtIn`. There is no path from `Flush` to data.
- **Back-to-back loads:** lw r1 → lw r2,(r1) → add r3,r2: two separate single-cycle stalls. `BubbleCount` increments by 2.
- **Reset mid-stall:** `Stall` drops to 0 in the cycle after the reset edge, because `Valid`=0.
- **Counter saturation:** held at max; no wrap.

## Configuration
- `ID_EX_HAZARD_DETECT_EN` **defined:** hazard logic as above.
- `ID_EX_HAZARD_DETECT_EN` **undefined:** `Haz` tied 0; `Stall` is constant 0; `BubbleCount` is constant 0. Only Flush and Rst create bubbles. Software must schedule a nop after every load.

## Test plan
- **Reset:** assert `Rst` for one edge with random inputs → all outputs 0, `Valid`=0, `Stall`=0.
- **Pass-through:** R-type add with `ALUOpIn`=2, `RegWriteIn`=1, `RdIn`=3 → next cycle `ALUOp`=2, `RegWrite`=1, `Rd`=3, `Valid`=1, `Stall`=0.
- **Load-use:**
  - In EX: lw with `Rt`=5.
  - In ID: add with `RsIn`=5.
  - Expected: `Stall`=1 that cycle; next edge `Valid`=0, `RegWrite`=0, `BubbleCount`=1.
  - Add presented again: `Stall`=0 and it loads.
- **$zero and non-load cases:**
  - lw with `Rt`=0 and `RsIn`=0 → `Stall`=0.
  - Non-load (`MemRead`=0) in EX with matching `Rt` → `Stall`=0.
- **Flush vs hazard:** hazard condition true and `Flush`=1 in the same cycle → `Stall`=0, bubble loaded, `BubbleCount` unchanged.
- **Saturation:** with `CNT_W`=2, produce 5 load-use stalls → `BubbleCount` reads 3. With macro undefined, the same stimulus gives `Stall`=0 and `BubbleCount`=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a saturating bubble counter.
// Hazard detection and the bubble counter exist only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegDstIn,
  input  logic              BranchIn,
  input  logic              MemReadIn,
  input  logic              MemtoRegIn,
  input  logic              MemWriteIn,
  input  logic              ALUSrcIn,
  input  logic              RegWriteIn,
  input  logic [3:0]        ALUOpIn,
  input  logic [DATA_W-1:0] ReadData1In,
  input  logic [DATA_W-1:0] ReadData2In,
  input  logic [DATA_W-1:0] ImmIn,
  input  logic [DATA_W-1:0] PCPlus4In,
  input  logic [4:0]        RsIn,
  input  logic [4:0]        RtIn,
  input  logic [4:0]        RdIn,
  input  logic              Flush,
  output logic              RegDst,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemtoReg,
  output logic              MemWrite,
  output logic              ALUSrc,
  output logic              RegWrite,
  output logic [3:0]        ALUOp,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] PCPlus4,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic              Valid,
  output logic              Stall,
  output logic [CNT_W-1:0]  BubbleCount
);

  typedef enum logic {S_BUBBLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_haz;
  logic               r_regdst, r_branch, r_memread, r_memtoreg;
  logic               r_memwrite, r_alusrc, r_regwrite;
  logic [3:0]         r_aluop;
  logic [DATA_W-1:0]  r_rd1, r_rd2, r_imm, r_pc4;
  logic [4:0]         r_rs, r_rt, r_rd;

`ifdef ID_EX_HAZARD_DETECT_EN
  // Load in EX whose destination is read by the instruction now in ID.
  assign w_haz = (r_state == S_RUN) & r_memread & (r_rt != 5'd0) &
                 ((r_rt == RsIn) | (r_rt == RtIn));
`else
  logic w_unused_fields;
  assign w_unused_fields = ^{RsIn, RtIn};
  assign w_haz = 1'b0;
`endif

  // Flush kills the dependent instruction anyway, so it also cancels the stall.
  assign Stall = w_haz & ~Flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_next = S_RUN;
    w_load       = 1'b1;
    if (Flush || w_haz) begin
      w_state_next = S_BUBBLE;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Rst) begin
      r_state    <= S_BUBBLE;
      r_regdst   <= 1'b0;
      r_branch   <= 1'b0;
      r_memread  <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_aluop    <= 4'd0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_rd       <= 5'd0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_regdst   <= RegDstIn;
        r_branch   <= BranchIn;
        r_memread  <= MemReadIn;
        r_memtoreg <= MemtoRegIn;
        r_memwrite <= MemWriteIn;
        r_alusrc   <= ALUSrcIn;
        r_regwrite <= RegWriteIn;
        r_aluop    <= ALUOpIn;
        r_rd1      <= ReadData1In;
        r_rd2      <= ReadData2In;
        r_imm      <= ImmIn;
        r_pc4      <= PCPlus4In;
        r_rs       <= RsIn;
        r_rt       <= RtIn;
        r_rd       <= RdIn;
      end else begin
        // Bubble: controls and register fields zeroed, data words left as they were.
        r_regdst   <= 1'b0;
        r_branch   <= 1'b0;
        r_memread  <= 1'b0;
        r_memtoreg <= 1'b0;
        r_memwrite <= 1'b0;
        r_alusrc   <= 1'b0;
        r_regwrite <= 1'b0;
        r_aluop    <= 4'd0;
        r_rs       <= 5'd0;
        r_rt       <= 5'd0;
        r_rd       <= 5'd0;
      end
    end
  end

`ifdef ID_EX_HAZARD_DETECT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_bubble_cnt <= '0;
    end else if (Stall && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign BubbleCount = r_bubble_cnt;
`else
  assign BubbleCount = '0;
`endif

  assign RegDst    = r_regdst;
  assign Branch    = r_branch;
  assign MemRead   = r_memread;
  assign MemtoReg  = r_memtoreg;
  assign MemWrite  = r_memwrite;
  assign ALUSrc    = r_alusrc;
  assign RegWrite  = r_regwrite;
  assign ALUOp     = r_aluop;
  assign ReadData1 = r_rd1;
  assign ReadData2 = r_rd2;
  assign Imm       = r_imm;
  assign PCPlus4   = r_pc4;
  assign Rs        = r_rs;
  assign Rt        = r_rt;
  assign Rd        = r_rd;
  assign Valid     = (r_state == S_RUN);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues expected Stall and registered EX state,
// a negedge monitor pops and compares. Expectations follow ID_EX_HAZARD_DETECT_EN.
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  typedef struct packed {
    logic        regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [3:0]  aluop;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } id_t;

  typedef struct packed {
    id_t        f;
    logic       valid;
    logic [1:0] bc;
    logic       chk_data;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Flush = 1'b0;
  id_t  in_v = '0;

  logic        RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Valid, Stall;
  logic [3:0]  ALUOp;
  logic [31:0] ReadData1, ReadData2, Imm, PCPlus4;
  logic [4:0]  Rs, Rt, Rd;
  logic [1:0]  BubbleCount;

  int n_checks = 0;
  int n_err = 0;

  bit   stall_chk_q[$];
  bit   stall_exp_q[$];
  exp_t reg_q[$];
  exp_t pend;
  bit   have_pend = 1'b0;

  always #5 Clk = ~Clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .RegDstIn(in_v.regdst), .BranchIn(in_v.branch), .MemReadIn(in_v.memread),
    .MemtoRegIn(in_v.memtoreg), .MemWriteIn(in_v.memwrite), .ALUSrcIn(in_v.alusrc),
    .RegWriteIn(in_v.regwrite), .ALUOpIn(in_v.aluop),
    .ReadData1In(in_v.rd1), .ReadData2In(in_v.rd2), .ImmIn(in_v.imm), .PCPlus4In(in_v.pc4),
    .RsIn(in_v.rs), .RtIn(in_v.rt), .RdIn(in_v.rd), .Flush(Flush),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm), .PCPlus4(PCPlus4),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Valid(Valid), .Stall(Stall), .BubbleCount(BubbleCount)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Monitor: Stall is checked in the cycle its inputs are presented,
  // registered state one cycle later.
  always begin
    @(negedge Clk);
    if (have_pend) begin
      check("ctrl", 32'({Valid, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp}),
            32'({pend.valid, pend.f.regdst, pend.f.branch, pend.f.memread, pend.f.memtoreg,
                 pend.f.memwrite, pend.f.alusrc, pend.f.regwrite, pend.f.aluop}));
      check("fields", 32'({Rs, Rt, Rd}), 32'({pend.f.rs, pend.f.rt, pend.f.rd}));
      check("bubble_count", 32'(BubbleCount), 32'(pend.bc));
      if (pend.chk_data) begin
        check("read_data1", ReadData1, pend.f.rd1);
        check("read_data2", ReadData2, pend.f.rd2);
        check("imm", Imm, pend.f.imm);
        check("pc_plus4", PCPlus4, pend.f.pc4);
      end
      have_pend = 1'b0;
    end
    if (stall_exp_q.size() > 0) begin
      automatic bit c = stall_chk_q.pop_front();
      automatic bit e = stall_exp_q.pop_front();
      if (c) check("stall", 32'(Stall), 32'(e));
    end
    if (reg_q.size() > 0) begin
      pend = reg_q.pop_front();
      have_pend = 1'b1;
    end
  end

  function automatic id_t mk_r(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
    id_t v = '0;
    v.regdst = 1'b1; v.regwrite = 1'b1; v.aluop = op;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.rd1 = 32'hA000_0000 | 32'(rs);
    v.rd2 = 32'hB000_0000 | 32'(rt);
    v.imm = 32'h0000_0C00 | 32'(rd);
    v.pc4 = 32'h0040_0000 + 32'(rd) * 4;
    return v;
  endfunction

  function automatic id_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_t v = '0;
    v.memread = 1'b1; v.memtoreg = 1'b1; v.alusrc = 1'b1; v.regwrite = 1'b1; v.aluop = 4'd2;
    v.rs = rs; v.rt = rt;
    v.rd1 = 32'hC000_0000 | 32'(rs);
    v.rd2 = 32'hD000_0000 | 32'(rt);
    v.imm = 32'hFFFF_FFF0;
    v.pc4 = 32'h0040_1000 + 32'(rt) * 4;
    return v;
  endfunction

  function automatic exp_t pass(input id_t v, input logic [1:0] bc);
    exp_t e;
    e.f = v; e.valid = 1'b1; e.bc = bc; e.chk_data = 1'b1;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [1:0] bc);
    exp_t e;
    e.f = '0; e.valid = 1'b0; e.bc = bc; e.chk_data = 1'b0;
    return e;
  endfunction

  function automatic exp_t zero_state();
    exp_t e;
    e.f = '0; e.valid = 1'b0; e.bc = 2'd0; e.chk_data = 1'b1;
    return e;
  endfunction

  task automatic step(input id_t v, input logic r, input logic fl, input bit chk_st,
                      input bit exp_st, input exp_t exp_r);
    @(posedge Clk);
    #1;
    in_v = v; Rst = r; Flush = fl;
    stall_chk_q.push_back(chk_st);
    stall_exp_q.push_back(exp_st);
    reg_q.push_back(exp_r);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    id_t rv, a1, l1, a2, sb, l0, az, l2, a3, ld, ad, l3, a4, sw, bq;
    logic [1:0] bc_before [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] bc_after  [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rv.regdst = 1'b1; rv.branch = 1'b1; rv.memread = 1'b1; rv.memtoreg = 1'b1;
    rv.memwrite = 1'b1; rv.alusrc = 1'b1; rv.regwrite = 1'b1;
    rv.aluop = 4'($urandom); rv.rd1 = $urandom; rv.rd2 = $urandom; rv.imm = $urandom;
    rv.pc4 = $urandom; rv.rs = 5'($urandom); rv.rt = 5'($urandom); rv.rd = 5'($urandom);

    // Reset with busy inputs; Stall is unknown before the first reset edge.
    step(rv, 1'b1, 1'b0, 1'b0, 1'b0, zero_state());
    step(rv, 1'b1, 1'b0, 1'b1, 1'b0, zero_state());

    a1 = mk_r(4'd2, 5'd1, 5'd2, 5'd3);
    step(a1, 1'b0, 1'b0, 1'b1, 1'b0, pass(a1, 2'd0));
    l1 = mk_lw(5'd4, 5'd5);
    step(l1, 1'b0, 1'b0, 1'b1, 1'b0, pass(l1, 2'd0));
    // Load-use on r5, then the same add presented again.
    a2 = mk_r(4'd2, 5'd5, 5'd7, 5'd6);
    step(a2, 1'b0, 1'b0, 1'b1, HAZ, HAZ ? bubble(2'd1) : pass(a2, 2'd0));
    step(a2, 1'b0, 1'b0, 1'b1, 1'b0, pass(a2, HAZ ? 2'd1 : 2'd0));
    // Non-load in EX whose Rt matches.
    sb = mk_r(4'd6, 5'd7, 5'd7, 5'd8);
    step(sb, 1'b0, 1'b0, 1'b1, 1'b0, pass(sb, HAZ ? 2'd1 : 2'd0));
    // Load to $zero followed by a reader of $zero.
    l0 = mk_lw(5'd9, 5'd0);
    step(l0, 1'b0, 1'b0, 1'b1, 1'b0, pass(l0, HAZ ? 2'd1 : 2'd0));
    az = mk_r(4'd2, 5'd0, 5'd0, 5'd10);
    step(az, 1'b0, 1'b0, 1'b1, 1'b0, pass(az, HAZ ? 2'd1 : 2'd0));
    // Flush together with a hazard: no stall, bubble, count unchanged.
    l2 = mk_lw(5'd9, 5'd11);
    step(l2, 1'b0, 1'b0, 1'b1, 1'b0, pass(l2, HAZ ? 2'd1 : 2'd0));
    a3 = mk_r(4'd2, 5'd11, 5'd3, 5'd12);
    step(a3, 1'b0, 1'b1, 1'b1, 1'b0, bubble(HAZ ? 2'd1 : 2'd0));

    // Five more load-use stalls drive the 2-bit counter into saturation.
    for (int i = 0; i < 5; i++) begin
      ld = mk_lw(5'd9, 5'(13 + i));
      step(ld, 1'b0, 1'b0, 1'b1, 1'b0, pass(ld, HAZ ? bc_before[i] : 2'd0));
      ad = mk_r(4'd7, 5'(13 + i), 5'd1, 5'(20 + i));
      step(ad, 1'b0, 1'b0, 1'b1, HAZ, HAZ ? bubble(bc_after[i]) : pass(ad, 2'd0));
    end

    // Reset in the middle of a stall clears everything; the retry then loads.
    l3 = mk_lw(5'd9, 5'd14);
    step(l3, 1'b0, 1'b0, 1'b1, 1'b0, pass(l3, HAZ ? 2'd3 : 2'd0));
    a4 = mk_r(4'd12, 5'd14, 5'd2, 5'd15);
    step(a4, 1'b1, 1'b0, 1'b1, HAZ, zero_state());
    step(a4, 1'b0, 1'b0, 1'b1, 1'b0, pass(a4, 2'd0));

    // Store and branch control bits pass through.
    sw = '0;
    sw.memwrite = 1'b1; sw.alusrc = 1'b1; sw.aluop = 4'd2; sw.rs = 5'd15; sw.rt = 5'd3;
    sw.rd1 = 32'h1234_5678; sw.rd2 = 32'h8765_4321; sw.imm = 32'd8; sw.pc4 = 32'h0040_2000;
    step(sw, 1'b0, 1'b0, 1'b1, 1'b0, pass(sw, 2'd0));
    bq = '0;
    bq.branch = 1'b1; bq.aluop = 4'd6; bq.rs = 5'd3; bq.rt = 5'd4;
    bq.rd1 = 32'h0000_0003; bq.rd2 = 32'h0000_0004; bq.imm = 32'hFFFF_FFFC; bq.pc4 = 32'h0040_2004;
    step(bq, 1'b0, 1'b0, 1'b1, 1'b0, pass(bq, 2'd0));

    repeat (3) @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
